// File: rtl/multiplier_pipe_nb.sv
// Three-stage pipelined WxW multiplier (unsigned or Baugh-Wooley signed) with
// valid/ready handshakes; carry-save reduction feeds a Kogge-Stone final adder.
module multiplier_pipe_nb #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    input  logic           sgn,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [2*W-1:0] o,
    output logic           out_valid,
    input  logic           out_ready
);

    localparam int P  = 2 * W;
    localparam int H  = W / 2;
    localparam int LG = $clog2(P);

    // One shifted partial-product row; in signed mode the cross terms that touch
    // exactly one operand MSB are inverted.
    function automatic logic [P-1:0] pp_row(input logic [W-1:0] xv, input logic yb,
                                            input int i, input logic s);
        logic [P-1:0] r;
        logic         t;
        r = {P{1'b0}};
        for (int j = 0; j < W; j++) begin
            t = xv[j] & yb;
            if (s && ((i == W - 1) != (j == W - 1))) begin
                t = ~t;
            end else begin
                t = t;
            end
            r[i+j] = t;
        end
        return r;
    endfunction

    function automatic logic [P-1:0] bw_const();
        logic [P-1:0] c;
        c      = {P{1'b0}};
        c[W]   = 1'b1;
        c[P-1] = 1'b1;
        return c;
    endfunction

    // Row-wise 3:2 compressor; returns {carry, sum}.
    function automatic logic [2*P-1:0] csa(input logic [P-1:0] a, input logic [P-1:0] b,
                                           input logic [P-1:0] c);
        logic [P-1:0] maj;
        maj = (a & b) | (a & c) | (b & c);
        return {maj[P-2:0], 1'b0, a ^ b ^ c};
    endfunction

    function automatic logic [P-1:0] ks_add(input logic [P-1:0] a, input logic [P-1:0] b);
        logic [P-1:0] g, p, p0, gp, ppv;
        g  = a & b;
        p  = a ^ b;
        p0 = p;
        for (int k = 0; k < LG; k++) begin
            gp  = g;
            ppv = p;
            g   = gp | (ppv & (gp << (1 << k)));
            p   = ppv & (ppv << (1 << k));
        end
        return p0 ^ {g[P-2:0], 1'b0};
    endfunction

    logic         v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [W-1:0] x1_q, x1_d, y1_q, y1_d;
    logic         sg1_q, sg1_d;
    logic [P-1:0] s1_q, s1_d, c1_q, c1_d;
    logic [P-1:0] a2_q, a2_d, b2_q, b2_d;
    logic [P-1:0] o_q, o_d;
    logic         en;
    logic         accept;

    assign en        = !v3_q | out_ready;
    assign in_ready  = en & !rst;
    assign accept    = in_valid & in_ready;
    assign out_valid = v3_q;
    assign o         = o_q;

    // Valid bits advance together, or all hold during a stall.
    always_comb begin
        v1_d = v1_q;
        v2_d = v2_q;
        v3_d = v3_q;
        if (en) begin
            v1_d = accept;
            v2_d = v1_q;
            v3_d = v2_q;
        end else begin
            v1_d = v1_q;
            v2_d = v2_q;
            v3_d = v3_q;
        end
    end

    // Stage 1: lower half of the partial-product rows folded into two rows.
    always_comb begin : stage1
        logic [P-1:0]   acc_s, acc_c;
        logic [2*P-1:0] cs;
        acc_s = sgn ? bw_const() : {P{1'b0}};
        acc_c = {P{1'b0}};
        cs    = {2*P{1'b0}};
        for (int i = 0; i < H; i++) begin
            cs    = csa(acc_s, acc_c, pp_row(x, y[i], i, sgn));
            acc_s = cs[P-1:0];
            acc_c = cs[2*P-1:P];
        end
        if (accept) begin
            s1_d  = acc_s;
            c1_d  = acc_c;
            x1_d  = x;
            y1_d  = y;
            sg1_d = sgn;
        end else begin
            s1_d  = s1_q;
            c1_d  = c1_q;
            x1_d  = x1_q;
            y1_d  = y1_q;
            sg1_d = sg1_q;
        end
    end

    // Stage 2: remaining rows compressed into the final sum/carry pair.
    always_comb begin : stage2
        logic [P-1:0]   acc_s, acc_c;
        logic [2*P-1:0] cs;
        acc_s = s1_q;
        acc_c = c1_q;
        cs    = {2*P{1'b0}};
        for (int i = H; i < W; i++) begin
            cs    = csa(acc_s, acc_c, pp_row(x1_q, y1_q[i], i, sg1_q));
            acc_s = cs[P-1:0];
            acc_c = cs[2*P-1:P];
        end
        if (en && v1_q) begin
            a2_d = acc_s;
            b2_d = acc_c;
        end else begin
            a2_d = a2_q;
            b2_d = b2_q;
        end
    end

    // Stage 3: carry-propagate add; o keeps its last product across bubbles.
    always_comb begin
        if (en && v2_q) begin
            o_d = ks_add(a2_q, b2_q);
        end else begin
            o_d = o_q;
        end
    end

    // Pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            x1_q  <= {W{1'b0}};
            y1_q  <= {W{1'b0}};
            sg1_q <= 1'b0;
            s1_q  <= {P{1'b0}};
            c1_q  <= {P{1'b0}};
            a2_q  <= {P{1'b0}};
            b2_q  <= {P{1'b0}};
            o_q   <= {P{1'b0}};
        end else begin
            v1_q  <= v1_d;
            v2_q  <= v2_d;
            v3_q  <= v3_d;
            x1_q  <= x1_d;
            y1_q  <= y1_d;
            sg1_q <= sg1_d;
            s1_q  <= s1_d;
            c1_q  <= c1_d;
            a2_q  <= a2_d;
            b2_q  <= b2_d;
            o_q   <= o_d;
        end
    end

endmodule

// File: tb/tb_multiplier_pipe_nb.sv
// Self-checking bench for multiplier_pipe_nb at W=4, 8, 16 and 32, compared
// against an integer-arithmetic reference product.
module tb_multiplier_pipe_nb;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] x_drv, y_drv;
    logic        sgn_drv;
    logic [3:0]  iv, ir, ov;
    logic        out_ready;
    logic [7:0]  o4;
    logic [15:0] o8;
    logic [31:0] o16;
    logic [63:0] o32;

    int          cur;
    logic [63:0] o_s;
    logic        ov_s, ir_s;
    int          n_chk, n_fail;
    logic [63:0] exp_q[$];

    localparam logic [7:0]  DX [4] = '{8'hFF, 8'h80, 8'hFF, 8'h7F};
    localparam logic [7:0]  DY [4] = '{8'hFF, 8'h80, 8'h01, 8'h80};
    localparam logic        DS [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    localparam logic [63:0] DO [4] = '{64'hFE01, 64'h4000, 64'hFFFF, 64'hC080};

    always #5 clk = ~clk;

    multiplier_pipe_nb #(.W(4)) u4 (.clk(clk), .rst(rst), .x(x_drv[3:0]), .y(y_drv[3:0]),
        .sgn(sgn_drv), .in_valid(iv[0]), .in_ready(ir[0]), .o(o4), .out_valid(ov[0]),
        .out_ready(out_ready));
    multiplier_pipe_nb #(.W(8)) u8 (.clk(clk), .rst(rst), .x(x_drv[7:0]), .y(y_drv[7:0]),
        .sgn(sgn_drv), .in_valid(iv[1]), .in_ready(ir[1]), .o(o8), .out_valid(ov[1]),
        .out_ready(out_ready));
    multiplier_pipe_nb #(.W(16)) u16 (.clk(clk), .rst(rst), .x(x_drv[15:0]), .y(y_drv[15:0]),
        .sgn(sgn_drv), .in_valid(iv[2]), .in_ready(ir[2]), .o(o16), .out_valid(ov[2]),
        .out_ready(out_ready));
    multiplier_pipe_nb #(.W(32)) u32 (.clk(clk), .rst(rst), .x(x_drv), .y(y_drv),
        .sgn(sgn_drv), .in_valid(iv[3]), .in_ready(ir[3]), .o(o32), .out_valid(ov[3]),
        .out_ready(out_ready));

    always_comb begin
        case (cur)
            0:       begin o_s = {56'h0, o4};  ov_s = ov[0]; ir_s = ir[0]; end
            1:       begin o_s = {48'h0, o8};  ov_s = ov[1]; ir_s = ir[1]; end
            2:       begin o_s = {32'h0, o16}; ov_s = ov[2]; ir_s = ir[2]; end
            default: begin o_s = o32;          ov_s = ov[3]; ir_s = ir[3]; end
        endcase
    end

    // Exact product of two w-bit operands, reduced to 2w bits.
    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                             input logic s, input int w);
        logic [63:0] au, bu, mask;
        longint      xa, yb, pr;
        au = {32'h0, a} & ({64{1'b1}} >> (64 - w));
        bu = {32'h0, b} & ({64{1'b1}} >> (64 - w));
        mask = {64{1'b1}} >> (64 - 2 * w);
        xa = longint'(au);
        yb = longint'(bu);
        if (s && au[w-1]) xa = xa - (longint'(1) << w);
        if (s && bu[w-1]) yb = yb - (longint'(1) << w);
        pr = xa * yb;
        return 64'(pr) & mask;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; iv = 4'b0; out_ready = 1'b1; cur = 1;
        step();
        step();
        n_chk++;
        if (ov !== 4'b0000) begin n_fail++; $display("FAIL reset_valid: got %b expected 0000", ov); end
        n_chk++;
        if (o_s !== 64'h0) begin n_fail++; $display("FAIL reset_o: got %h expected 0", o_s); end
        n_chk++;
        if (ir !== 4'b0000) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0000", ir); end
        rst = 1'b0;
        #1;
        n_chk++;
        if (ir !== 4'b1111) begin n_fail++; $display("FAIL reset_release_ready: got %b expected 1111", ir); end
    endtask

    task automatic test_directed();
        cur = 1; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            x_drv = {24'h0, DX[k]}; y_drv = {24'h0, DY[k]}; sgn_drv = DS[k]; iv[1] = 1'b1;
            n_chk++;
            if (ir_s !== 1'b1) begin n_fail++; $display("FAIL dir_ready[%0d]: got %b expected 1", k, ir_s); end
            step();
            iv[1] = 1'b0;
            step();
            n_chk++;
            if (ov_s !== 1'b0) begin n_fail++; $display("FAIL dir_early[%0d]: got %b expected 0", k, ov_s); end
            step();
            n_chk++;
            if (ov_s !== 1'b1 || o_s !== DO[k])
                begin n_fail++; $display("FAIL dir_prod[%0d]: got v=%b o=%h expected v=1 o=%h", k, ov_s, o_s, DO[k]); end
            step();
        end
    endtask

    task automatic test_back_to_back();
        int first, last, cnt;
        logic [31:0] xv, yv;
        logic sv;
        logic [63:0] e;
        first = -1; last = -1; cnt = 0;
        cur = 1; out_ready = 1'b1; exp_q.delete();
        for (int c = 0; c < 16; c++) begin
            if (c < 10) begin
                xv = $urandom; yv = $urandom; sv = ((c % 2) == 1);
                x_drv = xv; y_drv = yv; sgn_drv = sv; iv[1] = 1'b1;
                exp_q.push_back(ref_prod(xv, yv, sv, 8));
            end else begin
                iv[1] = 1'b0;
            end
            step();
            if (ov_s) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
                n_chk++;
                if (o_s !== e) begin n_fail++; $display("FAIL b2b_prod[%0d]: got %h expected %h", cnt, o_s, e); end
                cnt++;
                if (first < 0) first = c;
                last = c;
            end
        end
        n_chk++;
        if (cnt != 10 || (last - first + 1) != 10)
            begin n_fail++; $display("FAIL b2b_run: got %0d results over %0d cycles expected 10 over 10", cnt, last - first + 1); end
    endtask

    task automatic test_bubble();
        logic [7:0] pat;
        logic [31:0] xv, yv;
        logic [63:0] e;
        pat = 8'h00; cur = 1; out_ready = 1'b1; exp_q.delete();
        for (int c = 0; c < 8; c++) begin
            if (c == 0 || c == 2) begin
                xv = $urandom; yv = $urandom;
                x_drv = xv; y_drv = yv; sgn_drv = 1'b1; iv[1] = 1'b1;
                exp_q.push_back(ref_prod(xv, yv, 1'b1, 8));
            end else begin
                iv[1] = 1'b0;
            end
            step();
            pat[c] = ov_s;
            if (ov_s) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
                n_chk++;
                if (o_s !== e) begin n_fail++; $display("FAIL bubble_prod[%0d]: got %h expected %h", c, o_s, e); end
            end
        end
        n_chk++;
        if (pat !== 8'b0001_0100) begin n_fail++; $display("FAIL bubble_pattern: got %b expected 00010100", pat); end
    endtask

    task automatic test_stall();
        int got;
        logic [31:0] xv, yv;
        logic sv;
        logic [63:0] e;
        cur = 1; out_ready = 1'b1; exp_q.delete(); got = 0;
        for (int c = 0; c < 3; c++) begin
            xv = $urandom; yv = $urandom; sv = $urandom_range(0, 1);
            x_drv = xv; y_drv = yv; sgn_drv = sv; iv[1] = 1'b1;
            exp_q.push_back(ref_prod(xv, yv, sv, 8));
            step();
        end
        iv[1] = 1'b0; out_ready = 1'b0;
        #1;
        for (int s = 0; s < 5; s++) begin
            n_chk++;
            if (ov_s !== 1'b1 || o_s !== exp_q[0] || ir_s !== 1'b0)
                begin n_fail++; $display("FAIL stall_hold[%0d]: got v=%b o=%h rdy=%b expected v=1 o=%h rdy=0", s, ov_s, o_s, ir_s, exp_q[0]); end
            step();
        end
        out_ready = 1'b1;
        #1;
        for (int c = 0; c < 8; c++) begin
            if (ov_s) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
                n_chk++;
                if (o_s !== e) begin n_fail++; $display("FAIL stall_drain[%0d]: got %h expected %h", got, o_s, e); end
                got++;
            end
            step();
        end
        n_chk++;
        if (got != 3 || exp_q.size() != 0)
            begin n_fail++; $display("FAIL stall_count: got %0d results expected 3", got); end
    endtask

    task automatic test_reset_mid();
        int stale;
        stale = 0; cur = 1; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            x_drv = $urandom; y_drv = $urandom; sgn_drv = 1'b0; iv[1] = 1'b1;
            step();
        end
        rst = 1'b1; iv[1] = 1'b0;
        #1;
        n_chk++;
        if (ir_s !== 1'b0) begin n_fail++; $display("FAIL midrst_ready_low: got %b expected 0", ir_s); end
        step();
        rst = 1'b0;
        #1;
        n_chk++;
        if (ov_s !== 1'b0 || o_s !== 64'h0 || ir_s !== 1'b1)
            begin n_fail++; $display("FAIL midrst_state: got v=%b o=%h rdy=%b expected v=0 o=0 rdy=1", ov_s, o_s, ir_s); end
        for (int c = 0; c < 6; c++) begin
            step();
            if (ov_s !== 1'b0) stale++;
        end
        n_chk++;
        if (stale != 0) begin n_fail++; $display("FAIL midrst_stale: got %0d valid cycles expected 0", stale); end
        exp_q.delete();
    endtask

    task automatic test_sweep(input int sel, input int n_ops, input bit exh);
        int w, sent, got, guard;
        logic [31:0] xv, yv;
        logic sv;
        logic [63:0] e;
        w = 4 << sel; sent = 0; got = 0; guard = 0;
        cur = sel; out_ready = 1'b1; exp_q.delete();
        #1;
        while (got < n_ops && guard < n_ops + 20) begin
            if (ov_s) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
                n_chk++;
                if (o_s !== e) begin n_fail++; $display("FAIL sweep_w%0d[%0d]: got %h expected %h", w, got, o_s, e); end
                got++;
            end
            if (sent < n_ops) begin
                if (exh) begin
                    xv = {28'h0, sent[7:4]}; yv = {28'h0, sent[3:0]}; sv = sent[8];
                end else begin
                    xv = $urandom; yv = $urandom; sv = $urandom_range(0, 1);
                end
                x_drv = xv; y_drv = yv; sgn_drv = sv; iv[sel] = 1'b1;
                n_chk++;
                if (ir_s !== 1'b1) begin n_fail++; $display("FAIL sweep_w%0d_ready: got %b expected 1", w, ir_s); end
                exp_q.push_back(ref_prod(xv, yv, sv, w));
                sent++;
            end else begin
                iv[sel] = 1'b0;
            end
            step();
            guard++;
        end
        iv = 4'b0;
        n_chk++;
        if (got != n_ops) begin n_fail++; $display("FAIL sweep_w%0d_count: got %0d expected %0d", w, got, n_ops); end
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cur = 1;
        x_drv = 32'h0; y_drv = 32'h0; sgn_drv = 1'b0; iv = 4'b0; out_ready = 1'b1; rst = 1'b1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_bubble();
        test_stall();
        test_reset_mid();
        test_sweep(0, 512, 1'b1);
        test_sweep(2, 10000, 1'b0);
        test_sweep(3, 10000, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
